// File: rtl/button_debounce.sv
// Five-way button front end: 2-flop synchroniser, per-bit debounce, registered
// press/release strobes and optional auto-repeat press ticks while a button is held.

module button_debounce_lane #(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_EN     = 0,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RMX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW  = (RMX > 1) ? $clog2(RMX) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic           s1, s2;
  logic [DBW-1:0] db_cnt;
  logic           diff, acc, rise, fall, tick;

  assign diff = (s2 != level);
  assign acc  = diff && (db_cnt == DB_LAST);
  assign rise = acc && !level;
  assign fall = acc && level;

  // Only s1 ever samples the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (!diff) begin
        db_cnt <= '0;
      end else if (acc) begin
        db_cnt <= '0;
        level  <= s2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      press <= rise | tick;
      rel   <= fall;
    end
  end

  if (REPEAT_EN != 0) begin : g_rpt
    typedef enum logic [1:0] {IDLE, HOLD, RPT} rpt_t;
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    rpt_t          state;
    logic [RW-1:0] rcnt;

    // A release accepted on the same edge as a tick wins; no stray press.
    assign tick = !fall && (((state == HOLD) && (rcnt == HOLD_LAST)) ||
                            ((state == RPT)  && (rcnt == REP_LAST)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        rcnt  <= '0;
      end else if (fall) begin
        state <= IDLE;
        rcnt  <= '0;
      end else begin
        case (state)
          IDLE: if (rise) begin
            state <= HOLD;
            rcnt  <= '0;
          end
          HOLD: if (rcnt == HOLD_LAST) begin
            state <= RPT;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
          RPT: rcnt <= (rcnt == REP_LAST) ? '0 : rcnt + 1'b1;
          default: begin
            state <= IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end else begin : g_norpt
    assign tick = 1'b0;
  end
endmodule

module button_debounce #(
  parameter int N_BTN         = 5,
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_EN     = 0,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    button_debounce_lane #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_EN     (REPEAT_EN),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i])
    );
  end

  assign any_press = |btn_press;
endmodule
